stim_sweep_gen: RTL

Parametrised hardware stimulus sequencer for the lab's combinational test blocks. It sweeps a WIDTH-bit input vector through every combination in binary, Gray or walking-one order. Each vector is held for a programmable dwell, and the block issues a sample strobe so a downstream checker or LED display can capture the DUT outputs. It sits between the board's button/switch inputs and the DUT input pins.

---
 rtl/stim_sweep_gen_pkg.sv | 25 ++
 rtl/stim_sweep_gen_if.sv | 50 +++++
 rtl/stim_sweep_gen_misr.sv | 28 ++
 rtl/stim_sweep_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/stim_sweep_gen_pkg.sv
// stim_sweep_gen shared package.
// Holds the mode codes, FSM states, MISR constants and the width helper.
package stim_sweep_pkg;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // x^16+x^12+x^5+1 : feedback taps sig[15], sig[11], sig[4]
    localparam logic [15:0] MISR_TAPS = 16'h8810;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic int idx_w(input int w);
        int c;
        c = $clog2(w + 1);
        return (c > w) ? c : w;
    endfunction

endpackage

// File: rtl/stim_sweep_gen_if.sv
// stim_sweep_gen control/stimulus bundle.
// master drives start/abort/mode/dwell; slave (the generator) drives
// stim_out, stim_valid, sample, step_idx, busy, done.
// With SWEEP_SIG_EN: master also drives resp_in, slave drives signature.
interface stim_sweep_gen_if #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8
);
    import stim_sweep_pkg::*;

    localparam int IDX_W = idx_w(WIDTH);

    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   stim_out;
    logic               stim_valid;
    logic               sample;
    logic [IDX_W-1:0]   step_idx;
    logic               busy;
    logic               done;
`ifdef SWEEP_SIG_EN
    logic [7:0]         resp_in;
    logic [15:0]        signature;

    modport master (
        output start, abort, mode, dwell, resp_in,
        input  stim_out, stim_valid, sample,
        input  step_idx, busy, done, signature
    );
    modport slave (
        input  start, abort, mode, dwell, resp_in,
        output stim_out, stim_valid, sample,
        output step_idx, busy, done, signature
    );
`else
    modport master (
        output start, abort, mode, dwell,
        input  stim_out, stim_valid, sample,
        input  step_idx, busy, done
    );
    modport slave (
        input  start, abort, mode, dwell,
        output stim_out, stim_valid, sample,
        output step_idx, busy, done
    );
`endif

endinterface

// File: rtl/stim_sweep_gen_misr.sv
// sweep_misr: 16-bit response signature register.
// Ports: clk, rst (sync, high), seed (reload), en (shift), resp_in, sig.
module sweep_misr
    import stim_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed,
    input  logic        en,
    input  logic [7:0]  resp_in,
    output logic [15:0] sig
);

    logic fb;

    assign fb = ^(sig & MISR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (seed) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], fb} ^ {8'h00, resp_in};
        end
    end

endmodule

// File: rtl/stim_sweep_gen.sv
// stim_sweep_gen: binary / Gray / walking-one stimulus sequencer.
// Ports: clk, rst (sync, high), s (stim_sweep_gen_if.slave).
// Optional SWEEP_SIG_EN adds a response MISR (resp_in -> signature).
module stim_sweep_gen
    import stim_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8
) (
    input logic            clk,
    input logic            rst,
    stim_sweep_gen_if.slave s
);

    localparam int IDX_W = idx_w(WIDTH);
    // one extra bit so 2^WIDTH steps is representable
    localparam int SW    = WIDTH + 1;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q, mode_d;
    logic [SW-1:0]      step_q, step_d;
    logic [WIDTH-1:0]   stim_q, stim_d;
    logic               sample;
    logic               last;

    function automatic logic [WIDTH-1:0] vec(
        input logic [1:0]    m,
        input logic [SW-1:0] i
    );
        logic [SW-1:0] g;
        g = i ^ (i >> 1);
        unique case (1'b1)
            (m == MODE_GRAY): return g[WIDTH-1:0];
            (m == MODE_WALK): return WIDTH'(1) << i;
            (m == MODE_BIN):  return i[WIDTH-1:0];
            default:          return i[WIDTH-1:0];
        endcase
    endfunction

    function automatic logic [SW-1:0] n_steps(input logic [1:0] m);
        return (m == MODE_WALK) ? SW'(WIDTH) : (SW'(1) << WIDTH);
    endfunction

    assign last = (step_q == n_steps(mode_q) - SW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        step_d  = step_q;
        stim_d  = stim_q;
        sample  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s.start && !s.abort) begin
                    state_d = RUN;
                    mode_d  = s.mode;
                    dwell_d = s.dwell;
                    cnt_d   = '0;
                    step_d  = '0;
                    stim_d  = vec(s.mode, '0);
                end
            end
            RUN: begin
                if (s.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == dwell_q) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (last) begin
                        state_d = FIN;
                    end else begin
                        step_d = step_q + SW'(1);
                        stim_d = vec(mode_q, step_q + SW'(1));
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= MODE_BIN;
            step_q  <= '0;
            stim_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            stim_q  <= stim_d;
        end
    end

    assign s.stim_out   = stim_q;
    assign s.stim_valid = (state_q == RUN);
    assign s.busy       = (state_q == RUN);
    assign s.done       = (state_q == FIN);
    assign s.sample     = sample;
    assign s.step_idx   = IDX_W'(step_q);

`ifdef SWEEP_SIG_EN
    logic seed;

    assign seed = (state_q == IDLE) && s.start && !s.abort;

    sweep_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .seed    (seed),
        .en      (sample),
        .resp_in (s.resp_in),
        .sig     (s.signature)
    );
`endif

endmodule
